// File: rtl/data_mem_master_if.sv
// rtl/data_mem_master_if.sv - request/response and data-memory bus bundle for data_mem_master
//
// Purpose: groups the core-side request/response handshake and the data-memory
//          bus into one interface so the master and its environment share one port.
// Signals:
//   req_valid/req_ready/req_we/req_size/req_unsigned/req_addr/req_wdata  core request
//   resp_valid/resp_rdata/resp_err                                        core response
//   mem_A/mem_WD/mem_WE/mem_RD                                            data memory
// Modports:
//   master : the load/store initiator (drives req_ready, resp_*, mem_A/WD/WE)
//   slave  : the environment (core drives req_*, memory drives mem_RD)
interface data_mem_master_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic [ADDR_WIDTH-1:0] mem_A;
    logic [31:0]           mem_WD;
    logic                  mem_WE;
    logic [31:0]           mem_RD;

    modport master (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_RD,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE
    );

    modport slave (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_RD,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_A, mem_WD, mem_WE
    );
endinterface

// File: rtl/data_mem_master.sv
// rtl/data_mem_master.sv - load/store initiator for the word-organised data memory
//
// Purpose: accepts byte-addressed loads/stores from the core, issues word accesses
//          to the data memory, performs read-modify-write for byte/half stores and
//          returns sign- or zero-extended load data.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset; aborts any operation in flight
//   bus  data_mem_master_if.master: req_* (in), req_ready/resp_* (out),
//        mem_A/mem_WD/mem_WE (out), mem_RD (in, combinational from mem_A)
// Parameters:
//   MEM_DEPTH   words in the attached memory; byte addresses >= 4*MEM_DEPTH are rejected
//   ADDR_WIDTH  width of req_addr and mem_A
// Configuration macro:
//   MISALIGN_CHK_EN  when defined, misaligned half/word requests are rejected;
//                    otherwise the low address bits below the access size are ignored.
module data_mem_master #(
    parameter int MEM_DEPTH  = 100,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_master_if.master    bus
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(4 * MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // Request fields captured at accept; the core holds req_* but we do not rely on it.
    logic                  l_we;
    logic [1:0]            l_size;
    logic                  l_uns;
    logic [ADDR_WIDTH-1:0] l_addr;
    logic [31:0]           l_wdata;
    logic                  l_err;

    logic [31:0]           rbuf;      // word read in READ, merge source for RMW
    logic [31:0]           rdata_q;   // last successful load result

    logic                  misalign;
    logic                  req_err;
    logic [ADDR_WIDTH-1:0] word_idx;

    // Pick the addressed lane out of a memory word and extend it to 32 bits.
    function automatic logic [31:0] load_extract(input logic [31:0] w,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lo,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lo, 3'b000} +: 8];
        h = lo[1] ? w[31:16] : w[15:0];
        case (size)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = w;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the old word with the low bits of the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lo);
        logic [31:0] r;
        r = old;
        case (size)
            2'b00: r[{lo, 3'b000} +: 8] = wdata[7:0];
            2'b01: begin
                if (lo[1]) r[31:16] = wdata[15:0];
                else       r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

    always_comb begin
`ifdef MISALIGN_CHK_EN
        misalign = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        misalign = 1'b0;
`endif
        req_err = (bus.req_size == 2'b11) || (bus.req_addr >= ADDR_LIMIT) || misalign;
    end

    assign word_idx = {2'b00, l_addr[ADDR_WIDTH-1:2]};

    // State register; reset forces IDLE so mem_WE and resp_valid drop immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_err   = 1'b0;
        bus.mem_A      = '0;
        bus.mem_WD     = 32'd0;
        bus.mem_WE     = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    if (req_err)                     state_nxt = RESP;
                    else if (!bus.req_we)            state_nxt = READ;
                    else if (bus.req_size == 2'b10)  state_nxt = WRITE;
                    else                             state_nxt = READ;  // sub-word RMW
                end
            end
            READ: begin
                bus.mem_A = word_idx;
                state_nxt = l_we ? WRITE : RESP;
            end
            WRITE: begin
                bus.mem_A  = word_idx;
                bus.mem_WE = 1'b1;
                bus.mem_WD = store_merge(rbuf, l_wdata, l_size, l_addr[1:0]);
                state_nxt  = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_err   = l_err;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            l_we    <= 1'b0;
            l_size  <= 2'b00;
            l_uns   <= 1'b0;
            l_addr  <= '0;
            l_wdata <= 32'd0;
            l_err   <= 1'b0;
            rbuf    <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            if ((state == IDLE) && bus.req_valid) begin
                l_we    <= bus.req_we;
                l_size  <= bus.req_size;
                l_uns   <= bus.req_unsigned;
                l_addr  <= bus.req_addr;
                l_wdata <= bus.req_wdata;
                l_err   <= req_err;
            end
            if (state == READ) begin
                rbuf <= bus.mem_RD;
                // Result is registered here so it is stable for the whole RESP cycle
                // and held afterwards; stores and errors never touch it.
                if (!l_we)
                    rdata_q <= load_extract(bus.mem_RD, l_size, l_addr[1:0], l_uns);
            end
        end
    end

    assign bus.resp_rdata = rdata_q;

endmodule

// File: tb/tb_data_mem_master.sv
// tb/tb_data_mem_master.sv - self-checking bench for data_mem_master
module tb_data_mem_master;

    localparam int MEM_DEPTH = 100;
`ifdef MISALIGN_CHK_EN
    localparam bit MIS = 1'b1;
`else
    localparam bit MIS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    always #5 clk = ~clk;

    data_mem_master_if #(.ADDR_WIDTH(32)) bus();

    data_mem_master #(.MEM_DEPTH(MEM_DEPTH), .ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Attached data memory: combinational read, write on rising edge.
    logic [31:0] mem [0:MEM_DEPTH-1];
    assign bus.mem_RD = (bus.mem_A < MEM_DEPTH) ? mem[bus.mem_A[6:0]] : 32'h0;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= 32'h0;
        end else if (bus.mem_WE && (bus.mem_A < MEM_DEPTH)) begin
            mem[bus.mem_A[6:0]] <= bus.mem_WD;
        end
    end

    // Reference model state.
    logic [31:0] ref_mem [0:MEM_DEPTH-1];
    logic [31:0] last_rdata;
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one request, predict its full cycle-by-cycle behaviour from the
    // byte-addressed model, and compare every cycle until the response.
    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit lit_en, input logic [31:0] lit);
        bit          err;
        bit          got;
        bit          access;
        int          lat;
        int          wcyc;
        int          idx;
        int          sh;
        logic [31:0] old;
        logic [31:0] v;
        logic [31:0] mask;
        logic [31:0] wd_exp;
        logic [31:0] rd_exp;

        err = (size == 2'b11) || (addr >= 4 * MEM_DEPTH) ||
              (MIS && (((size == 2'b01) && (addr % 2 != 0)) ||
                       ((size == 2'b10) && (addr % 4 != 0))));
        idx    = int'(addr / 4);
        wcyc   = 0;
        wd_exp = 32'h0;
        rd_exp = last_rdata;
        old    = 32'h0;
        if (err) begin
            lat = 1;
        end else begin
            old = ref_mem[idx];
            if (size == 2'b00) sh = 8 * int'(addr % 4);
            else               sh = 16 * int'((addr / 2) % 2);
            if (!we) begin
                lat = 2;
                if (size == 2'b00) begin
                    v = (old >> sh) & 32'hFF;
                    rd_exp = (uns || v < 128) ? v : (v | 32'hFFFF_FF00);
                end else if (size == 2'b01) begin
                    v = (old >> sh) & 32'hFFFF;
                    rd_exp = (uns || v < 32768) ? v : (v | 32'hFFFF_0000);
                end else begin
                    rd_exp = old;
                end
                last_rdata = rd_exp;
            end else if (size == 2'b10) begin
                lat = 2; wcyc = 1; wd_exp = wdata;
            end else begin
                lat = 3; wcyc = 2;
                mask   = ((size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
                wd_exp = (old & ~mask) | ((wdata << sh) & mask);
            end
            if (we) ref_mem[idx] = wd_exp;
        end

        @(negedge clk);
        check("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        bus.req_valid    = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;

        got = 1'b0;
        for (int k = 1; k <= 6 && !got; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            access = !err && (k < lat);
            check("mem_WE", 32'(bus.mem_WE), 32'(k == wcyc));
            check("mem_A", bus.mem_A, access ? 32'(idx) : 32'h0);
            check("mem_WD", bus.mem_WD, (k == wcyc) ? wd_exp : 32'h0);
            if (lit_en && we && (k == wcyc)) check("mem_WD_literal", bus.mem_WD, lit);
            check("req_ready_busy", 32'(bus.req_ready), 32'd0);
            check("resp_valid_timing", 32'(bus.resp_valid), 32'(k == lat));
            if (bus.resp_valid) begin
                got = 1'b1;
                check("resp_err", 32'(bus.resp_err), 32'(err));
                check("resp_rdata", bus.resp_rdata, rd_exp);
                if (lit_en && !we) check("resp_rdata_literal", bus.resp_rdata, lit);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL resp_timeout addr=%h actual=none expected=resp_valid", addr);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit we_seen;

        for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = 32'h0;
        last_rdata       = 32'h0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'h0;
        bus.req_wdata    = 32'h0;
        mem_clr          = 1'b1;
        rst              = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_mem_WE", 32'(bus.mem_WE), 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'h0);
        check("rst_mem_A", bus.mem_A, 32'h0);
        check("rst_mem_WD", bus.mem_WD, 32'h0);
        mem_clr = 1'b0;
        rst     = 1'b0;

        // Word store / load round trip
        do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0,         1'b1, 32'hDEAD_BEEF);
        // Byte RMW and byte loads
        do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00A5, 1'b1, 32'hDEAD_A5EF);
        do_req(1'b0, 2'b00, 1'b0, 32'h11, 32'h0,         1'b1, 32'hFFFF_FFA5);
        do_req(1'b0, 2'b00, 1'b1, 32'h11, 32'h0,         1'b1, 32'h0000_00A5);
        // Half loads, upper lane
        do_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0,         1'b1, 32'hFFFF_DEAD);
        do_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0,         1'b1, 32'h0000_DEAD);
        // Errors: past the end, reserved size, store past the end
        do_req(1'b0, 2'b10, 1'b0, 32'h190, 32'h0,        1'b0, 32'h0);
        do_req(1'b0, 2'b11, 1'b0, 32'h10,  32'h0,        1'b0, 32'h0);
        do_req(1'b1, 2'b10, 1'b0, 32'h190, 32'h1234_5678, 1'b0, 32'h0);
        // Last valid word
        do_req(1'b1, 2'b10, 1'b0, 32'h18C, 32'h0BAD_F00D, 1'b1, 32'h0BAD_F00D);
        do_req(1'b0, 2'b10, 1'b0, 32'h18C, 32'h0,         1'b1, 32'h0BAD_F00D);
        // Half store upper lane, byte store lane 3, mixed loads
        do_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h5555_CAFE, 1'b1, 32'hCAFE_0000);
        do_req(1'b0, 2'b10, 1'b0, 32'h20, 32'h0,         1'b1, 32'hCAFE_0000);
        do_req(1'b1, 2'b00, 1'b0, 32'h23, 32'h1234_5681, 1'b1, 32'h81FE_0000);
        do_req(1'b0, 2'b00, 1'b0, 32'h23, 32'h0,         1'b1, 32'hFFFF_FF81);
        do_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0,         1'b1, 32'h0000_0000);
        // Misaligned word load @0x13
`ifdef MISALIGN_CHK_EN
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0,         1'b0, 32'h0);
        do_req(1'b0, 2'b01, 1'b1, 32'h11, 32'h0,         1'b0, 32'h0);
`else
        do_req(1'b0, 2'b10, 1'b0, 32'h13, 32'h0,         1'b1, 32'hDEAD_A5EF);
        do_req(1'b0, 2'b01, 1'b1, 32'h11, 32'h0,         1'b1, 32'h0000_A5EF);
`endif

        // Reset during READ of a byte store: the write must never happen.
        @(negedge clk);
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b00;
        bus.req_addr  = 32'h10;
        bus.req_wdata = 32'h0000_0077;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        check("abort_in_read_mem_A", bus.mem_A, 32'd4);
        we_seen = bus.mem_WE;
        rst = 1'b1;
        #1;
        check("abort_req_ready", 32'(bus.req_ready), 32'd1);
        check("abort_mem_A", bus.mem_A, 32'h0);
        last_rdata = 32'h0;
        repeat (2) begin
            @(negedge clk);
            we_seen = we_seen | bus.mem_WE;
        end
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            we_seen = we_seen | bus.mem_WE;
            check("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
        end
        check("abort_mem_WE_never", 32'(we_seen), 32'd0);
        check("abort_mem_word", mem[4], ref_mem[4]);
        check("abort_resp_rdata", bus.resp_rdata, 32'h0);

        // Normal operation resumes after the abort.
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_A5EF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
